ble_cmd_controller: RTL
=======================

BLE_CMD_CONTROLLER -- requirements
Module: ble_cmd_controller

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, default 742500, maximum idle cycles between bytes inside a packet (10 ms at 74.25 MHz); LINK_FRAMES, default 30, count of new_frame_in pulses without a good packet before the link is declared lost.
REQ-002 Ports (clock and reset first) SHALL be:
  clk_in  in  1  pixel clock, the only clock.
  rst_in  in  1  reset, asynchronous, active-low.
  byte_in  in  8  received UART byte.
  byte_valid_in  in  1  one-cycle strobe qualifying byte_in.
  new_frame_in  in  1  one-cycle frame pulse.
  ble_enable_in  in  1  1 = BLE commands participate in arbitration.
  hit_btn_in  in  1  local hit button (already synchronized).
  pan_left_sw_in  in  1  local pan-left switch.
  pan_right_sw_in  in  1  local pan-right switch.
  charging_hit_out  out  1  arbitrated hit level to gameplay.
  pan_left_out  out  1  arbitrated pan-left level.
  pan_right_out  out  1  arbitrated pan-right level.
  new_game_out  out  1  one-cycle new-game pulse.
  link_active_out  out  1  1 = good packet within last LINK_FRAMES frames.
  last_cmd_out  out  8  command byte of last good packet.
  pkt_ok_count_out  out  8  good-packet count, saturating.
  pkt_err_count_out  out  8  bad-packet count, saturating.

Function
REQ-003 Packet format SHALL be 4 bytes: 0xA5 header, CMD, ARG, CHK, where CHK = CMD ^ ARG ^ 0x5A.
REQ-004 Parser FSM SHALL have states IDLE, GOT_HDR, GOT_CMD, GOT_ARG, and advance one state per byte_valid_in.
REQ-005 In IDLE, 0xA5 SHALL move to GOT_HDR; any other byte SHALL be discarded with no error count.
REQ-006 Outside IDLE, every byte including 0xA5 SHALL be taken as data; no mid-packet resynchronization.
REQ-007 The CHK byte SHALL always return the FSM to IDLE; on mismatch, pkt_err_count_out SHALL increment and no command SHALL be applied.
REQ-008 Outside IDLE, an idle counter SHALL clear on each byte_valid_in; when it reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE and pkt_err_count_out SHALL increment.
REQ-009 If byte_valid_in coincides with the timeout cycle, the byte SHALL win: no timeout, byte processed normally.
REQ-010 Good-packet commands SHALL be:
  0x01 sets BLE hit latch.
  0x02 clears BLE hit latch.
  0x03 loads BLE pan latches (left = ARG[0], right = ARG[1]).
  0x04 issues new_game_out pulse.
  Any other CMD counts as an error (pkt_err_count_out++), not a good packet.
REQ-011 On a good packet, pkt_ok_count_out SHALL increment, last_cmd_out SHALL load CMD, link_active_out SHALL be set, and the frame counter SHALL clear.
REQ-012 Both counters SHALL saturate at 255 and never wrap.
REQ-013 While link_active_out=1, each new_frame_in SHALL increment the frame counter; at LINK_FRAMES, link_active_out SHALL clear and all BLE hit/pan latches SHALL clear.
REQ-014 If new_frame_in coincides with good-packet completion, the packet SHALL win (counter cleared).
REQ-015 Arbitration:
  charging_hit_out = hit_btn_in | (ble_enable_in & hit latch).
  Pan outputs are likewise ORed per direction.
  If both pan directions result 1, both outputs SHALL be 0.
REQ-016 All outputs SHALL be registered.
REQ-017 Local-input latency to outputs SHALL be 1 cycle.
REQ-018 A CHK byte accepted at edge N SHALL affect outputs (latches, pulse, counters, last_cmd_out) at edge N+2.
REQ-019 new_game_out SHALL be exactly one cycle wide, and SHALL be suppressed when ble_enable_in=0 (packet still counted ok).

Reset
REQ-020 Asserting rst_in low SHALL immediately, asynchronously:
  force FSM to IDLE;
  clear all latches and counters;
  drive every output to 0.
REQ-021 Reset asserted mid-packet SHALL discard the partial packet with no error count.
REQ-022 Reset deassertion SHALL be synchronized to clk_in; the first byte is accepted on the second edge after release.

Verification
REQ-023 Good hit: ble_enable_in=1, bytes A5,01,00,5B -> charging_hit_out=1 two cycles after CHK; ok=1, last_cmd=0x01, link_active=1.
REQ-024 Bad checksum: bytes A5,03,01,00 -> pan outputs stay 0, err=1, ok=0; following A5,03,01,58 -> pan_left_out=1.
REQ-025 Timeout: A5,01 then silence for TIMEOUT_CYCLES -> err=1, FSM IDLE; next A5,02,00,58 accepted (ok=1).
REQ-026 Pan conflict: BLE pan ARG=0x01 plus pan_right_sw_in=1 -> pan_left_out=0, pan_right_out=0.
REQ-027 Link loss: after good 0x01 packet, 30 new_frame_in pulses with no packet -> link_active_out=0 and charging_hit_out=0 (hit_btn_in=0).
REQ-028 Saturation/reset: 300 good packets -> ok=255; rst_in low mid-packet -> all outputs 0 at once, err unchanged at 0.

Source files
------------

// File: rtl/ble_cmd_controller.sv
// BLE command packet parser and arbiter: merges validated UART packet commands with
// local controls. Status counters and link supervision are tracked alongside.
module ble_cmd_controller #(
  parameter int TIMEOUT_CYCLES = 742500,
  parameter int LINK_FRAMES    = 30
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  input  logic       new_frame_in,
  input  logic       ble_enable_in,
  input  logic       hit_btn_in,
  input  logic       pan_left_sw_in,
  input  logic       pan_right_sw_in,
  output logic       charging_hit_out,
  output logic       pan_left_out,
  output logic       pan_right_out,
  output logic       new_game_out,
  output logic       link_active_out,
  output logic [7:0] last_cmd_out,
  output logic [7:0] pkt_ok_count_out,
  output logic [7:0] pkt_err_count_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(LINK_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD, GOT_ARG} state_t;

  state_t        state_reg;
  logic          run_reg;
  logic [TW-1:0] idle_cnt_reg;
  logic [7:0]    cmd_reg, arg_reg;
  logic          ev_good_reg, ev_err_reg;

  logic          hit_latch_reg, pan_l_latch_reg, pan_r_latch_reg, game_reg, link_reg;
  logic [7:0]    ok_cnt_reg, err_cnt_reg, last_cmd_reg;
  logic [FW-1:0] frame_cnt_reg;

  logic          pan_l_req, pan_r_req;

  // Stage 1: byte parser. run_reg holds off byte acceptance for one edge after reset release.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg    <= IDLE;
      run_reg      <= 1'b0;
      idle_cnt_reg <= '0;
      cmd_reg      <= '0;
      arg_reg      <= '0;
      ev_good_reg  <= 1'b0;
      ev_err_reg   <= 1'b0;
    end else begin
      run_reg     <= 1'b1;
      ev_good_reg <= 1'b0;
      ev_err_reg  <= 1'b0;
      if (run_reg) begin
        if (byte_valid_in) begin
          idle_cnt_reg <= '0;
          case (state_reg)
            IDLE:    if (byte_in == 8'hA5) state_reg <= GOT_HDR;
            GOT_HDR: begin cmd_reg <= byte_in; state_reg <= GOT_CMD; end
            GOT_CMD: begin arg_reg <= byte_in; state_reg <= GOT_ARG; end
            default: begin
              state_reg <= IDLE;
              if (byte_in == (cmd_reg ^ arg_reg ^ 8'h5A) && cmd_reg >= 8'h01 && cmd_reg <= 8'h04)
                ev_good_reg <= 1'b1;
              else
                ev_err_reg <= 1'b1;
            end
          endcase
        end else if (state_reg != IDLE) begin
          // A byte on the timeout cycle takes the branch above, so the byte wins.
          if (idle_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            state_reg    <= IDLE;
            ev_err_reg   <= 1'b1;
            idle_cnt_reg <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
      end
    end
  end

  // Stage 2: apply packet results to latches, counters and link supervision.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_latch_reg   <= 1'b0;
      pan_l_latch_reg <= 1'b0;
      pan_r_latch_reg <= 1'b0;
      game_reg        <= 1'b0;
      link_reg        <= 1'b0;
      ok_cnt_reg      <= '0;
      err_cnt_reg     <= '0;
      last_cmd_reg    <= '0;
      frame_cnt_reg   <= '0;
    end else begin
      game_reg <= 1'b0;
      if (ev_err_reg && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
      if (ev_good_reg) begin
        if (ok_cnt_reg != 8'hFF) ok_cnt_reg <= ok_cnt_reg + 8'd1;
        last_cmd_reg  <= cmd_reg;
        link_reg      <= 1'b1;
        frame_cnt_reg <= '0;
        case (cmd_reg)
          8'h01:   hit_latch_reg <= 1'b1;
          8'h02:   hit_latch_reg <= 1'b0;
          8'h03:   begin pan_l_latch_reg <= arg_reg[0]; pan_r_latch_reg <= arg_reg[1]; end
          default: game_reg <= 1'b1;
        endcase
      end else if (link_reg && new_frame_in) begin
        if (frame_cnt_reg == FW'(LINK_FRAMES - 1)) begin
          link_reg        <= 1'b0;
          frame_cnt_reg   <= '0;
          hit_latch_reg   <= 1'b0;
          pan_l_latch_reg <= 1'b0;
          pan_r_latch_reg <= 1'b0;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign pan_l_req = pan_left_sw_in  | (ble_enable_in & pan_l_latch_reg);
  assign pan_r_req = pan_right_sw_in | (ble_enable_in & pan_r_latch_reg);

  // Stage 3: registered outputs; conflicting pan requests cancel each other.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      charging_hit_out  <= 1'b0;
      pan_left_out      <= 1'b0;
      pan_right_out     <= 1'b0;
      new_game_out      <= 1'b0;
      link_active_out   <= 1'b0;
      last_cmd_out      <= '0;
      pkt_ok_count_out  <= '0;
      pkt_err_count_out <= '0;
    end else begin
      charging_hit_out  <= hit_btn_in | (ble_enable_in & hit_latch_reg);
      pan_left_out      <= pan_l_req & ~pan_r_req;
      pan_right_out     <= pan_r_req & ~pan_l_req;
      new_game_out      <= game_reg & ble_enable_in;
      link_active_out   <= link_reg;
      last_cmd_out      <= last_cmd_reg;
      pkt_ok_count_out  <= ok_cnt_reg;
      pkt_err_count_out <= err_cnt_reg;
    end
  end

endmodule
